// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// abort reason codes and the default frame start byte.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_COUNT   = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // States in which the inter-byte idle timeout is armed.
  function automatic logic in_frame(state_e s);
    return s inside {ST_CNT_HI, ST_CNT_LO, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/m_prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface m_prog_loader_if;
  logic       w_bvalid;
  logic [7:0] w_bdata;
  logic       w_bready;

  modport master (output w_bvalid, output w_bdata, input w_bready);
  modport slave  (input w_bvalid, input w_bdata, output w_bready);
endinterface

// File: rtl/m_idle_timer.sv
// Saturating idle-cycle counter; expired_o is high once TIMEOUT consecutive
// cycles have passed without clr_i.
module m_idle_timer #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic w_clk,
  input  logic w_rst_n,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (cnt_q != LIMIT) cnt_d = cnt_q + CW'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // The cycle whose edge would be the TIMEOUT-th without a handshake.
  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/m_prog_loader.sv
// Framed byte-stream loader for the instruction memory: MAGIC, big-endian
// word count, little-endian words, 8-bit checksum; holds the core in reset.
module m_prog_loader
  import loader_pkg::*;
#(
  parameter logic [7:0]  MAGIC   = DEFAULT_MAGIC,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  m_prog_loader_if.slave    bus,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_we,
  output logic [31:0]       w_din,
  output logic              w_hold,
  output logic              w_done,
  output logic              w_err,
  output logic [1:0]        w_errcode
);

  // Word index is one bit wider so a full 2^ADDR_W frame never wraps.
  localparam int unsigned IW = ADDR_W + 1;
  localparam logic [IW-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [IW-1:0]     nwords_q, nwords_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        bsel_q, bsel_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       din_q, din_d;
  logic              bready_q, bready_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  err_e              errcode_q, errcode_d;

  logic          hs;
  logic [7:0]    byte_in;
  logic [15:0]   count_w;
  logic [IW-1:0] idx_next;
  logic          timer_clr;
  logic          timer_expired;

  assign hs       = bus.w_bvalid && bready_q;
  assign byte_in  = bus.w_bdata;
  assign count_w  = {cnt_hi_q, byte_in};
  assign idx_next = idx_q + IW'(1);

  // NOTE: every signal written here gets its default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    nwords_d  = nwords_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    bsel_d    = bsel_q;
    csum_d    = csum_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    din_d     = din_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    errcode_d = errcode_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (hs && byte_in == MAGIC) begin
          state_d   = ST_CNT_HI;
          hold_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          errcode_d = ERR_NONE;
          csum_d    = '0;
          idx_d     = '0;
          addr_d    = '0;
          bsel_d    = '0;
        end
      end
      ST_CNT_HI: begin
        if (hs) begin
          cnt_hi_d = byte_in;
          csum_d   = csum_q + byte_in;
          state_d  = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (hs) begin
          csum_d = csum_q + byte_in;
          if (count_w > 16'(MAX_WORDS)) begin
            state_d   = ST_ERR;
            err_d     = 1'b1;
            errcode_d = ERR_COUNT;
          end else if (count_w == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            nwords_d = count_w[IW-1:0];
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (hs) begin
          csum_d = csum_q + byte_in;
          if (bsel_q == 2'd3) begin
            we_d   = 1'b1;
            din_d  = {byte_in, asm_q};
            addr_d = idx_q[ADDR_W-1:0];
            idx_d  = idx_next;
            bsel_d = '0;
            if (idx_next == nwords_q) state_d = ST_CSUM;
          end else begin
            // Shift in from the top so the first byte ends up in bits [7:0].
            asm_d  = {byte_in, asm_q[23:8]};
            bsel_d = bsel_q + 2'd1;
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          if (byte_in == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d   = ST_ERR;
            err_d     = 1'b1;
            errcode_d = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_frame(state_q) && !hs && timer_expired) begin
      state_d   = ST_ERR;
      err_d     = 1'b1;
      errcode_d = ERR_TIMEOUT;
    end

    // One bubble after each completed word gives the memory a quiet cycle.
    bready_d = !we_d;
  end

  assign timer_clr = hs || (state_d != state_q) || !in_frame(state_q);

  m_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .clr_i     (timer_clr),
    .expired_o (timer_expired)
  );

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_hi_q  <= '0;
      nwords_q  <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
      bsel_q    <= '0;
      csum_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      din_q     <= '0;
      bready_q  <= 1'b1;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      errcode_q <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      cnt_hi_q  <= cnt_hi_d;
      nwords_q  <= nwords_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      bsel_q    <= bsel_d;
      csum_q    <= csum_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      din_q     <= din_d;
      bready_q  <= bready_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
      errcode_q <= errcode_d;
    end
  end

  assign bus.w_bready = bready_q;
  assign w_addr       = addr_q;
  assign w_we         = we_q;
  assign w_din        = din_q;
  assign w_hold       = hold_q;
  assign w_done       = done_q;
  assign w_err        = err_q;
  assign w_errcode    = errcode_q;

endmodule

// File: tb/tb_m_prog_loader.sv
// Self-checking bench for m_prog_loader: frame vectors from a table, memory
// writes checked against a scoreboard queue, plus hand-written corner cases.
module tb_m_prog_loader;
  import loader_pkg::*;

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned TIMEOUT = 16;

  logic              w_clk = 1'b0;
  logic              w_rst_n = 1'b0;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [31:0]       w_din;
  logic              w_hold;
  logic              w_done;
  logic              w_err;
  logic [1:0]        w_errcode;

  m_prog_loader_if bus ();

  m_prog_loader #(
    .MAGIC   (8'hA5),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .bus       (bus),
    .w_addr    (w_addr),
    .w_we      (w_we),
    .w_din     (w_din),
    .w_hold    (w_hold),
    .w_done    (w_done),
    .w_err     (w_err),
    .w_errcode (w_errcode)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected memory writes, filled as frames are driven.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  bit  watch_bready = 1'b0;
  int  bready_drops = 0;

  always @(negedge w_clk) begin
    if (watch_bready && !bus.w_bready) bready_drops++;
    if (w_we) begin
      check("bready low in write cycle", 32'(bus.w_bready), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected write: addr 0x%0h data 0x%0h, none expected", w_addr, w_din);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write addr", 32'(w_addr), 32'(mon_exp.addr));
        check("write data", w_din, mon_exp.data);
      end
    end
  end

  task automatic push_write(input int a, input logic [31:0] d);
    wr_t t;
    t.addr = ADDR_W'(a);
    t.data = d;
    exp_q.push_back(t);
  endtask

  // Present a byte at a negedge and return at the negedge after its handshake.
  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits = 0;
    bus.w_bvalid = 1'b1;
    bus.w_bdata  = b;
    while (!bus.w_bready && waits < 8) begin
      @(negedge w_clk);
      waits++;
    end
    if (!bus.w_bready) begin
      n_checks++;
      n_errors++;
      $display("FAIL bready wait: still low after %0d cycles, expected high", waits);
    end
    @(negedge w_clk);
  endtask

  task automatic idle(input int n);
    bus.w_bvalid = 1'b0;
    repeat (n) @(negedge w_clk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic [1:0] code, input logic hold);
    check({tag, " done"},    32'(w_done),    32'(done));
    check({tag, " err"},     32'(w_err),     32'(err));
    check({tag, " errcode"}, 32'(w_errcode), 32'(code));
    check({tag, " hold"},    32'(w_hold),    32'(hold));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " bready"}, 32'(bus.w_bready), 32'd1);
    check({tag, " addr"},   32'(w_addr),       32'd0);
    check({tag, " we"},     32'(w_we),         32'd0);
    check({tag, " din"},    w_din,             32'd0);
    check_status(tag, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  typedef struct {
    logic [0:11][7:0] bytes;
    int               len;
    int               nw;
    logic [0:1][31:0] w;
    logic             done;
    logic             err;
    logic [1:0]       code;
    logic             hold;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  cs;
    logic [31:0] word;
    int          k;

    // Checksum 0x7C is the mod-256 sum of 00 02 and the eight data bytes.
    vecs[0] = '{bytes: {8'hA5, 8'h00, 8'h02, 8'h13, 8'h00, 8'h01, 8'h20,
                        8'h24, 8'h00, 8'h02, 8'h20, 8'h7C},
                len: 12, nw: 2, w: {32'h2001_0013, 32'h2002_0024},
                done: 1'b1, err: 1'b0, code: 2'd0, hold: 1'b0};
    vecs[1] = vecs[0];
    vecs[1].bytes[11] = 8'h00;
    vecs[1].done = 1'b0;
    vecs[1].err  = 1'b1;
    vecs[1].code = 2'd2;
    vecs[1].hold = 1'b1;
    vecs[2] = vecs[0];
    vecs[3] = '{bytes: {8'hA5, 8'h08, 8'h01, 72'h0},
                len: 3, nw: 0, w: {32'h0, 32'h0},
                done: 1'b0, err: 1'b1, code: 2'd1, hold: 1'b1};

    bus.w_bvalid = 1'b0;
    bus.w_bdata  = 8'h00;
    repeat (2) @(negedge w_clk);
    check_reset("reset");
    w_rst_n = 1'b1;
    @(negedge w_clk);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].nw; i++) push_write(i, vecs[v].w[i]);
      send_byte(vecs[v].bytes[0]);
      check_status($sformatf("vec%0d after magic", v), 1'b0, 1'b0, 2'd0, 1'b1);
      for (int i = 1; i < vecs[v].len; i++) send_byte(vecs[v].bytes[i]);
      check_status($sformatf("vec%0d end", v), vecs[v].done, vecs[v].err,
                   vecs[v].code, vecs[v].hold);
      check($sformatf("vec%0d pending writes", v), 32'(exp_q.size()), 32'd0);
      idle(3);
    end

    // Largest legal frame: 2^ADDR_W words, last write at the top address.
    send_byte(8'hA5);
    send_byte(8'h08);
    send_byte(8'h00);
    cs = 8'h08;
    for (int i = 0; i < 2048; i++) begin
      word = 32'hC0DE_0000 | 32'(i);
      push_write(i, word);
      for (int b = 0; b < 4; b++) begin
        send_byte(word[8*b +: 8]);
        cs = cs + word[8*b +: 8];
      end
    end
    send_byte(cs);
    check_status("max count", 1'b1, 1'b0, 2'd0, 1'b0);
    check("max count last addr", 32'(w_addr), 32'h7FF);
    check("max count pending writes", 32'(exp_q.size()), 32'd0);
    idle(3);

    // Stall mid-word: error must appear exactly TIMEOUT cycles after the last byte.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.w_bvalid = 1'b0;
    k = 0;
    while (!w_err && k < 40) begin
      @(negedge w_clk);
      k++;
    end
    check("timeout latency", 32'(k), 32'(TIMEOUT));
    check_status("timeout", 1'b0, 1'b1, 2'd3, 1'b1);
    idle(3);

    // Reset after two data bytes, then a clean reload from address 0.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h13);
    send_byte(8'h00);
    bus.w_bvalid = 1'b0;
    w_rst_n = 1'b0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    check_reset("mid-frame reset");
    for (int i = 0; i < vecs[0].nw; i++) push_write(i, vecs[0].w[i]);
    for (int i = 0; i < vecs[0].len; i++) send_byte(vecs[0].bytes[i]);
    check_status("reload", 1'b1, 1'b0, 2'd0, 1'b0);
    check("reload pending writes", 32'(exp_q.size()), 32'd0);
    idle(3);

    // Junk bytes then an empty frame, valid held high throughout.
    watch_bready = 1'b1;
    send_byte(8'h00);
    send_byte(8'hFF);
    check_status("junk discarded", 1'b1, 1'b0, 2'd0, 1'b0);
    send_byte(8'hA5);
    check("empty frame started", 32'(w_done), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    watch_bready = 1'b0;
    check_status("empty frame", 1'b1, 1'b0, 2'd0, 1'b0);
    check("empty frame bready drops", 32'(bready_drops), 32'd0);
    check("empty frame pending writes", 32'(exp_q.size()), 32'd0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
